music_rec: RTL

- Recorder counterpart to the tune player.
- Samples a 1-bit square-wave input and measures its period in prescaled ticks.
- Once per note slot, writes the measured period as one 16-bit word into tune memory through a single-port write interface.
- Finishes the tune with the end-of-tune marker (bit 14 set), so the player can play it back unchanged.

---
 rtl/music_rec.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/music_rec.sv
// music_rec: measures a square-wave period in prescaled ticks and writes one
// tune word per note slot. Define MUSIC_REC_AVG_EN to store a two-period average.
module music_rec #(
    parameter int DIV        = 1024,
    parameter int SLOT_SHIFT = 11,
    parameter int DEPTH      = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rflag,
    input  logic [3:0]  rperiod,
    input  logic        min,
    output logic        wen,
    output logic [15:0] wadr,
    output logic [15:0] wdata,
    output logic        busy,
    output logic        done
);
    localparam int          PW       = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [13:0] PMAX     = 14'h3FFF;
    localparam logic [13:0] PMAX_M1  = 14'h3FFE;
    localparam logic [15:0] LAST_ADR = 16'(DEPTH - 2);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_TERM, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [PW-1:0] r_p;
    logic [13:0]   r_pcnt, r_last;
    logic [19:0]   r_scnt;
    logic [15:0]   r_adr, r_wadr, r_wdata;
    logic          r_s1, r_s2, r_s3, r_rise, r_rflag_d, r_seen, r_have;
    logic          w_tick, w_slot_end, w_start;
    logic [3:0]    w_rp;
    logic [19:0]   w_slot_len;
    logic [15:0]   w_word;

`ifdef MUSIC_REC_AVG_EN
    logic [13:0] r_prev;
    logic [1:0]  r_ncap;
    logic [14:0] w_sum;

    assign w_sum  = {1'b0, r_last} + {1'b0, r_prev} + 15'd1;
    assign w_word = !r_have ? 16'h0000 :
                    (r_ncap == 2'd2) ? {2'b00, w_sum[14:1]} : {2'b00, r_last};
`else
    assign w_word = r_have ? {2'b00, r_last} : 16'h0000;
`endif

    assign w_rp       = (rperiod == 4'd0) ? 4'd1 : rperiod;
    assign w_slot_len = 20'(w_rp) << SLOT_SHIFT;
    assign w_tick     = (r_state == S_REC) && (r_p == PW'(DIV));
    assign w_slot_end = w_tick && ((r_scnt + 20'd1) == w_slot_len);
    assign w_start    = (r_state == S_IDLE) && rflag && !r_rflag_d;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_REC;
            S_REC: begin
                if ((w_slot_end && r_adr == LAST_ADR) || !rflag)
                    w_next = S_TERM;
            end
            S_TERM: w_next = S_DONE;
            S_DONE: if (!rflag) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Address/data hold their last written value between strobes.
    always_comb begin
        wen   = 1'b0;
        wadr  = r_wadr;
        wdata = r_wdata;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            S_REC: begin
                busy = 1'b1;
                if (w_slot_end) begin
                    wen   = 1'b1;
                    wadr  = r_adr;
                    wdata = w_word;
                end
            end
            S_TERM: begin
                busy  = 1'b1;
                wen   = 1'b1;
                wadr  = r_adr;
                wdata = 16'h4000;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_rise    <= 1'b0;
            r_rflag_d <= 1'b0;
            r_wadr    <= '0;
            r_wdata   <= '0;
            r_p       <= '0;
            r_pcnt    <= '0;
            r_scnt    <= '0;
            r_adr     <= '0;
            r_last    <= '0;
            r_seen    <= 1'b0;
            r_have    <= 1'b0;
`ifdef MUSIC_REC_AVG_EN
            r_prev    <= '0;
            r_ncap    <= '0;
`endif
        end else begin
            r_s1      <= min;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_rise    <= r_s2 & ~r_s3;
            r_rflag_d <= rflag;
            r_wadr    <= wadr;
            r_wdata   <= wdata;
            if (w_start) begin
                r_p    <= '0;
                r_pcnt <= '0;
                r_scnt <= '0;
                r_adr  <= '0;
                r_last <= '0;
                r_seen <= 1'b0;
                r_have <= 1'b0;
`ifdef MUSIC_REC_AVG_EN
                r_prev <= '0;
                r_ncap <= '0;
`endif
            end else if (r_state == S_REC) begin
                r_p <= w_tick ? '0 : r_p + 1'b1;
                if (w_tick)
                    r_scnt <= w_slot_end ? 20'd0 : r_scnt + 20'd1;
                if (w_slot_end) begin
                    r_adr  <= r_adr + 16'd1;
                    r_have <= 1'b0;
`ifdef MUSIC_REC_AVG_EN
                    r_ncap <= 2'd0;
`endif
                end
                // An edge beats a coincident tick and starts the next period.
                if (r_rise) begin
                    r_pcnt <= '0;
                    r_seen <= 1'b1;
                    if (r_seen) begin
                        r_last <= r_pcnt;
                        r_have <= 1'b1;
`ifdef MUSIC_REC_AVG_EN
                        r_prev <= r_last;
                        r_ncap <= w_slot_end ? 2'd1 :
                                  (r_ncap == 2'd2) ? 2'd2 : r_ncap + 2'd1;
`endif
                    end
                end else if (w_tick && r_pcnt != PMAX) begin
                    r_pcnt <= r_pcnt + 14'd1;
                    if (r_pcnt == PMAX_M1) begin
                        r_have <= 1'b0;
                        r_seen <= 1'b0;
`ifdef MUSIC_REC_AVG_EN
                        r_ncap <= 2'd0;
`endif
                    end
                end
            end
        end
    end
endmodule
